// File: rtl/vga_pkg.sv
// Shared display constants, FSM state type and axis helpers for sprite motion.
package vga_pkg;

  localparam int COORD_W  = 10;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_STEP       = 2'd2,
    ST_COMMIT     = 2'd3
  } motion_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] p;
    logic               dir;
  } axis_t;

  // Pull an axis back inside a freshly applied bound; a zero bound parks it at 0 heading up.
  function automatic axis_t clamp_axis(axis_t a, logic [COORD_W-1:0] max_val);
    axis_t r;
    r = a;
    if (max_val == '0) begin
      r.p   = '0;
      r.dir = 1'b1;
    end else if (a.p > max_val) begin
      r.p   = max_val;
      r.dir = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_bounce.sv
// One-axis step: move one pixel along dir, reverse on reaching either bound.
module axis_bounce
  import vga_pkg::*;
(
  input  logic [COORD_W-1:0] p,
  input  logic               dir,
  input  logic [COORD_W-1:0] max_val,
  output logic [COORD_W-1:0] p_next,
  output logic               dir_next,
  output logic               reversed
);

  logic up;

  // Next coordinate/direction; a position already sitting on a bound is walked back inside.
  always_comb begin
    p_next   = p;
    dir_next = dir;
    reversed = 1'b0;
    up       = dir;
    if (max_val == '0) begin
      p_next   = '0;
      dir_next = 1'b1;
    end else begin
      if (dir && (p >= max_val)) begin
        p_next = max_val - COORD_W'(1);
        up     = 1'b0;
      end else if (!dir && (p == '0)) begin
        p_next = COORD_W'(1);
        up     = 1'b1;
      end else if (dir) begin
        p_next = p + COORD_W'(1);
      end else begin
        p_next = p - COORD_W'(1);
      end
      if (p_next == max_val)  dir_next = 1'b0;
      else if (p_next == '0)  dir_next = 1'b1;
      else                    dir_next = up;
      reversed = (dir_next != dir);
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-paced bouncing sprite origin with a double-buffered bounds/divider config.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | motion disabled, outputs hold
// ST_WAIT_FRAME| counting frame_start pulses against the divider
// ST_STEP     | next coordinates computed and registered
// ST_COMMIT   | new position visible, pos_valid (and bounce) pulse
module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int H_MAX     = 500,
  parameter int V_MAX     = 440,
  parameter int FRAME_DIV = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [COORD_W-1:0] cfg_hmax,
  input  logic [COORD_W-1:0] cfg_vmax,
  input  logic [7:0]         cfg_div,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               pos_valid,
  output logic               bounce
);

  motion_state_t state, state_nxt;

  logic [1:0]         rst_sync;
  logic               run_ok;
  logic [COORD_W-1:0] hmax_reg, vmax_reg, sh_hmax, sh_vmax;
  logic [7:0]         div_reg, sh_div, frame_cnt, eff_cnt, eff_div;
  logic               pend, apply, counting, div_hit, bounce_q;
  logic [COORD_W-1:0] nx, ny;
  logic               ndx, ndy, rev_x, rev_y;
  axis_t              clamp_x, clamp_y;

  assign run_ok    = rst_sync[1];
  assign cfg_ready = ~pend;
  assign apply     = pend && frame_start && ((state == ST_IDLE) || (state == ST_WAIT_FRAME));
  assign eff_cnt   = apply ? 8'd0 : frame_cnt;
  assign eff_div   = apply ? sh_div : div_reg;
  assign counting  = (state == ST_WAIT_FRAME) && enable && frame_start;
  assign div_hit   = counting && (eff_cnt == eff_div);
  assign clamp_x   = clamp_axis('{p: pos_x, dir: dir_x}, sh_hmax);
  assign clamp_y   = clamp_axis('{p: pos_y, dir: dir_y}, sh_vmax);
  assign pos_valid = (state == ST_COMMIT);
  assign bounce    = pos_valid && bounce_q;

  axis_bounce u_axis_x (.p(pos_x), .dir(dir_x), .max_val(hmax_reg),
                        .p_next(nx), .dir_next(ndx), .reversed(rev_x));
  axis_bounce u_axis_y (.p(pos_y), .dir(dir_y), .max_val(vmax_reg),
                        .p_next(ny), .dir_next(ndy), .reversed(rev_y));

  // Reset asserts at once but releases the FSM only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; frame_start is only looked at while waiting for a frame.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:       if (enable && run_ok) state_nxt = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (!enable)          state_nxt = ST_IDLE;
                     else if (div_hit)     state_nxt = ST_STEP;
      ST_STEP:       state_nxt = ST_COMMIT;
      ST_COMMIT:     state_nxt = enable ? ST_WAIT_FRAME : ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Position/direction: stepped on leaving STEP, clamped when new bounds land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x    <= '0;
      pos_y    <= '0;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      bounce_q <= 1'b0;
    end else if (state == ST_STEP) begin
      pos_x    <= nx;
      pos_y    <= ny;
      dir_x    <= ndx;
      dir_y    <= ndy;
      bounce_q <= rev_x | rev_y;
    end else if (apply) begin
      pos_x <= clamp_x.p;
      dir_x <= clamp_x.dir;
      pos_y <= clamp_y.p;
      dir_y <= clamp_y.dir;
    end
  end

  // Config shadow capture, apply on frame boundary, and frame divider count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      sh_hmax   <= '0;
      sh_vmax   <= '0;
      sh_div    <= '0;
      hmax_reg  <= COORD_W'(H_MAX);
      vmax_reg  <= COORD_W'(V_MAX);
      div_reg   <= 8'(FRAME_DIV);
      frame_cnt <= '0;
    end else begin
      if (apply) begin
        hmax_reg <= sh_hmax;
        vmax_reg <= sh_vmax;
        div_reg  <= sh_div;
        pend     <= 1'b0;
      end else if (cfg_valid && !pend) begin
        sh_hmax <= cfg_hmax;
        sh_vmax <= cfg_vmax;
        sh_div  <= cfg_div;
        pend    <= 1'b1;
      end
      if (counting)   frame_cnt <= div_hit ? 8'd0 : eff_cnt + 8'd1;
      else if (apply) frame_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: vector table plus multi-cycle sequences.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       frame_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [9:0] cfg_hmax = '0, cfg_vmax = '0;
  logic [7:0] cfg_div = '0;
  logic [9:0] pos_x, pos_y;
  logic       dir_x, dir_y, pos_valid, bounce;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [9:0] mx, my, mhx, mvy;
  logic       mdx, mdy, mb;
  logic [31:0] last_obs;

  typedef struct {
    logic        fs;
    logic        en;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_hmax(cfg_hmax),
    .cfg_vmax(cfg_vmax), .cfg_div(cfg_div), .pos_x(pos_x), .pos_y(pos_y),
    .dir_x(dir_x), .dir_y(dir_y), .pos_valid(pos_valid), .bounce(bounce)
  );

  function automatic logic [31:0] mk(input logic pv, input logic bn, input logic dx,
                                     input logic dy, input logic rdy,
                                     input logic [9:0] x, input logic [9:0] y);
    return {7'd0, pv, bn, dx, dy, rdy, x, y};
  endfunction

  function automatic logic [31:0] obs();
    return {7'd0, pos_valid, bounce, dir_x, dir_y, cfg_ready, pos_x, pos_y};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_axis(input logic [9:0] p, input logic d, input logic [9:0] m,
                            output logic [9:0] np, output logic nd, output logic r);
    if (m == 10'd0) begin
      np = '0; nd = 1'b1; r = 1'b0;
    end else begin
      np = d ? p + 10'd1 : p - 10'd1;
      nd = d;
      if (np == m)          nd = 1'b0;
      else if (np == 10'd0) nd = 1'b1;
      r = (nd != d);
    end
  endtask

  task automatic model_step();
    logic [9:0] nx, ny;
    logic ndx, ndy, rx, ry;
    model_axis(mx, mdx, mhx, nx, ndx, rx);
    model_axis(my, mdy, mvy, ny, ndy, ry);
    mx = nx; my = ny; mdx = ndx; mdy = ndy; mb = rx | ry;
  endtask

  task automatic model_clamp();
    if (mhx == 10'd0) begin mx = '0; mdx = 1'b1; end
    else if (mx > mhx) begin mx = mhx; mdx = 1'b0; end
    if (mvy == 10'd0) begin my = '0; mdy = 1'b1; end
    else if (my > mvy) begin my = mvy; mdy = 1'b0; end
  endtask

  // One stepping frame: nothing at t+1, committed position at t+2.
  task automatic do_step();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check("step_t1_no_valid", {31'd0, pos_valid}, 32'd0);
    @(negedge clk);
    model_step();
    last_obs = obs();
    check("step_commit", last_obs, mk(1'b1, mb, mdx, mdy, 1'b1, mx, my));
    @(negedge clk);
  endtask

  // A frame that must not commit.
  task automatic do_idle_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("idle_frame_no_valid", {31'd0, pos_valid}, 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic send_cfg(input logic [9:0] h, input logic [9:0] v, input logic [7:0] d);
    @(negedge clk);
    cfg_hmax = h; cfg_vmax = v; cfg_div = d; cfg_valid = 1'b1;
    @(negedge clk) cfg_valid = 1'b0;
    check("cfg_accept_ready_low", {31'd0, cfg_ready}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 10'd0, 10'd0)};
    vecs[1]  = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 10'd1, 10'd1)};
    vecs[2]  = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 10'd1, 10'd1)};
    vecs[3]  = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 10'd1, 10'd1)};
    vecs[4]  = '{1'b1, 1'b1, mk(1, 0, 1, 1, 1, 10'd2, 10'd2)};
    vecs[5]  = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 10'd2, 10'd2)};
    vecs[6]  = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 10'd2, 10'd2)};
    vecs[7]  = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 10'd3, 10'd3)};
    vecs[8]  = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 10'd3, 10'd3)};
    vecs[9]  = '{1'b0, 1'b0, mk(0, 0, 1, 1, 1, 10'd3, 10'd3)};
    vecs[10] = '{1'b1, 1'b0, mk(0, 0, 1, 1, 1, 10'd3, 10'd3)};
    vecs[11] = '{1'b0, 1'b0, mk(0, 0, 1, 1, 1, 10'd3, 10'd3)};
    vecs[12] = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 10'd3, 10'd3)};
    vecs[13] = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 10'd3, 10'd3)};
    vecs[14] = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 10'd4, 10'd4)};
    vecs[15] = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 10'd4, 10'd4)};

    repeat (2) @(negedge clk);
    check("reset_state", obs(), mk(0, 0, 1, 1, 1, 10'd0, 10'd0));
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("after_release", obs(), mk(0, 0, 1, 1, 1, 10'd0, 10'd0));

    // basic stepping, ignored frame_start in STEP/COMMIT/IDLE
    for (int i = 0; i < 16; i++) begin
      frame_start = vecs[i].fs;
      enable      = vecs[i].en;
      @(negedge clk);
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    frame_start = 1'b0;
    enable = 1'b1;

    mx = 10'd4; my = 10'd4; mdx = 1'b1; mdy = 1'b1; mhx = 10'd500; mvy = 10'd440; mb = 1'b0;

    // run up to the right edge (y bounces off 440 on the way)
    for (int k = 0; k < 600 && mx != 10'd499; k++) do_step();
    check("reached_499", {22'd0, pos_x}, 32'd499);
    do_step();
    check("hit_max", last_obs & 32'h01A0_FFC00, mk(1, 1, 0, 0, 0, 10'd500, 10'd0) & 32'h01A0_FFC00);
    do_step();
    check("after_max", {21'd0, last_obs[24], last_obs[22], last_obs[19:10]},
          {21'd0, 1'b1, 1'b0, 10'd499});

    for (int k = 0; k < 300 && mx != 10'd300; k++) do_step();

    // shrink bound below current x; held cfg_valid must not overwrite shadow
    @(negedge clk);
    cfg_hmax = 10'd200; cfg_vmax = 10'd440; cfg_div = 8'd0; cfg_valid = 1'b1;
    @(negedge clk);
    check("cfg_ready_drop", {31'd0, cfg_ready}, 32'd0);
    cfg_hmax = 10'd7;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_ready_still_low", {31'd0, cfg_ready}, 32'd0);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    mhx = 10'd200;
    model_clamp();
    check("clamp_no_valid", obs(), mk(0, 0, 1'b0, mdy, 1, 10'd200, my));
    @(negedge clk);
    model_step();
    check("clamp_then_step", obs(), mk(1, mb, mdx, mdy, 1, 10'd199, my));
    @(negedge clk);

    // divider of 2: every third frame commits, counting the apply frame
    send_cfg(10'd200, 10'd440, 8'd2);
    repeat (3) @(negedge clk);
    check("ready_until_apply", {31'd0, cfg_ready}, 32'd0);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check("div_apply_frame", {30'd0, pos_valid, cfg_ready}, 32'd1);
    @(negedge clk);
    check("div_apply_frame_t2", {31'd0, pos_valid}, 32'd0);
    @(negedge clk);
    do_idle_frame();
    do_step();
    do_idle_frame();
    do_idle_frame();
    do_step();

    send_cfg(10'd500, 10'd440, 8'd0);
    mhx = 10'd500;
    model_clamp();
    do_step();

    // zero-width axis: x parked at 0 heading up
    send_cfg(10'd0, 10'd440, 8'd0);
    mhx = 10'd0;
    model_clamp();
    do_step();
    do_step();
    check("hmax0_hold", {21'd0, last_obs[22], last_obs[19:10]}, {21'd0, 1'b1, 10'd0});
    send_cfg(10'd500, 10'd440, 8'd0);
    mhx = 10'd500;
    do_step();

    // enable dropped during STEP: commit still happens, then idle
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    enable = 1'b0;
    check("en_drop_step", {31'd0, pos_valid}, 32'd0);
    @(negedge clk);
    model_step();
    check("en_drop_commit", obs(), mk(1, mb, mdx, mdy, 1, mx, my));
    @(negedge clk);
    do_idle_frame();
    do_idle_frame();
    check("idle_hold", {12'd0, pos_x, pos_y}, {12'd0, mx, my});
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // reset during STEP discards the update
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_in_step", obs(), mk(0, 0, 1, 1, 1, 10'd0, 10'd0));
    @(negedge clk);
    check("rst_in_step_hold", obs(), mk(0, 0, 1, 1, 1, 10'd0, 10'd0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    mx = '0; my = '0; mdx = 1'b1; mdy = 1'b1; mhx = 10'd500; mvy = 10'd440;
    do_step();

    // reset asserted while in COMMIT: outputs drop asynchronously
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(posedge clk);
    #1;
    check("in_commit", {31'd0, pos_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_in_commit", obs(), mk(0, 0, 1, 1, 1, 10'd0, 10'd0));
    @(negedge clk);
    check("rst_in_commit_hold", obs(), mk(0, 0, 1, 1, 1, 10'd0, 10'd0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    mx = '0; my = '0; mdx = 1'b1; mdy = 1'b1;
    do_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
